// File: rtl/wave_pipe_pkg.sv
// rtl/wave_pipe_pkg.sv - shared types and constants for the waveform pipe-out buffer
//
// Purpose: half-select encoding for the 32-to-16 serialiser, pointer width
// helper, and drop counter width. Imported by wave_pipe_out.
// Ports: none (package).
package wave_pipe_pkg;

   // Which half of the head sample is presented to the host next.
   typedef enum logic {
      HALF_HI = 1'b0,   // bits [31:16], always sent first
      HALF_LO = 1'b1    // bits [15:0]
   } half_t;

   localparam int DROP_CNT_W = 16;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/wave_pipe_ram.sv
// rtl/wave_pipe_ram.sv - simple dual-port DEPTH x 32 sample RAM with synchronous read
//
// Purpose: sample storage for wave_pipe_out, written to map onto block RAM.
// Ports:
//   pipe_clk  in   single clock for both ports
//   wr_en     in   write strobe
//   wr_addr   in   write address
//   wr_data   in   32-bit sample to store
//   rd_addr   in   read address, sampled every cycle
//   rd_data   out  registered read data (old contents on same-address write)
module wave_pipe_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          pipe_clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge pipe_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/wave_pipe_out.sv
// rtl/wave_pipe_out.sv - waveform capture FIFO serialising 32-bit samples into 16-bit pipe-out words
//
// Purpose: buffers fabric samples and presents them, high half first, to a
// block-throttled pipe-out endpoint with show-ahead registered data.
// Ports:
//   pipe_clk        in   single clock
//   reset           in   synchronous, active-high
//   capture_en      in   gates capture of wave_valid
//   wave_valid      in   one-cycle sample strobe
//   wave_in         in   32-bit sample
//   pipe_out_read   in   host read strobe, one per 16-bit word
//   pipe_out_data   out  current head word (0 when nothing available)
//   pipe_out_ready  out  words_avail >= BLOCK_WORDS
//   words_avail     out  16-bit words available
//   full            out  all DEPTH entries occupied
//   empty           out  no word available
//   overflow        out  sticky: a sample was dropped
//   underflow       out  sticky: read while empty
//   drop_count      out  dropped samples, saturating
module wave_pipe_out
   import wave_pipe_pkg::*;
#(
   parameter  int DEPTH       = 1024,
   parameter  int BLOCK_WORDS = 256,
   localparam int PW          = ptr_width(DEPTH),
   localparam int AW          = PW - 1,
   localparam int WW          = PW + 1
) (
   input  logic                  pipe_clk,
   input  logic                  reset,
   input  logic                  capture_en,
   input  logic                  wave_valid,
   input  logic [31:0]           wave_in,
   input  logic                  pipe_out_read,
   output logic [15:0]           pipe_out_data,
   output logic                  pipe_out_ready,
   output logic [WW-1:0]         words_avail,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow,
   output logic                  underflow,
   output logic [DROP_CNT_W-1:0] drop_count
);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   half_t         half_sel;
   logic [31:0]   head;          // entry at rd_ptr, valid while entries > 0
   logic          last_push;     // write-tracking for the RAM read-after-write gap
   logic [PW-1:0] last_wr_ptr;
   logic [31:0]   last_wr_data;

   logic          push;
   logic          rd_ok;
   logic          pop;
   logic [PW-1:0] entries;
   logic [PW-1:0] entries_nxt;
   logic [PW-1:0] rd_ptr_inc;
   half_t         half_nxt;
   logic [31:0]   pop_src;
   logic [31:0]   head_nxt;
   logic [WW-1:0] words_nxt;
   logic [31:0]   ram_rd_data;

   assign push        = capture_en & wave_valid & ~full;
   assign rd_ok       = pipe_out_read & ~empty;
   assign pop         = rd_ok & (half_sel == HALF_LO);
   assign entries     = wr_ptr - rd_ptr;
   assign rd_ptr_inc  = rd_ptr + PW'(1);
   assign entries_nxt = entries + PW'(push) - PW'(pop);

   // The RAM continuously fetches the entry behind the head. A pop needs
   // half_sel=LO, so rd_ptr has been stable for at least one cycle before any
   // pop and ram_rd_data already holds that entry, except when it was written
   // in the last cycle or is being written right now; those are bypassed.
   wave_pipe_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .pipe_clk (pipe_clk),
      .wr_en    (push & ~reset),
      .wr_addr  (wr_ptr[AW-1:0]),
      .wr_data  (wave_in),
      .rd_addr  (rd_ptr_inc[AW-1:0]),
      .rd_data  (ram_rd_data)
   );

   always_comb begin
      pop_src = ram_rd_data;
      if (push && (wr_ptr == rd_ptr_inc)) begin
         pop_src = wave_in;
      end else if (last_push && (last_wr_ptr == rd_ptr_inc)) begin
         pop_src = last_wr_data;
      end

      head_nxt = head;
      if (pop) begin
         head_nxt = pop_src;
      end else if ((entries == '0) && push) begin
         head_nxt = wave_in;
      end

      half_nxt = half_sel;
      if (rd_ok) begin
         half_nxt = (half_sel == HALF_HI) ? HALF_LO : HALF_HI;
      end

      words_nxt = {entries_nxt, 1'b0} - WW'(half_nxt == HALF_LO);
   end

   always_ff @(posedge pipe_clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         half_sel       <= HALF_HI;
         head           <= '0;
         last_push      <= 1'b0;
         last_wr_ptr    <= '0;
         last_wr_data   <= '0;
         pipe_out_data  <= '0;
         pipe_out_ready <= 1'b0;
         words_avail    <= '0;
         full           <= 1'b0;
         empty          <= 1'b1;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
         drop_count     <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         half_sel       <= half_nxt;
         head           <= head_nxt;
         last_push      <= push;
         last_wr_ptr    <= wr_ptr;
         last_wr_data   <= wave_in;
         words_avail    <= words_nxt;
         empty          <= (words_nxt == '0);
         full           <= (entries_nxt == PW'(DEPTH));
         pipe_out_ready <= (words_nxt >= WW'(BLOCK_WORDS));
         // Show-ahead: the register always holds the word the next read consumes.
         if (words_nxt == '0) begin
            pipe_out_data <= 16'h0000;
         end else if (half_nxt == HALF_HI) begin
            pipe_out_data <= head_nxt[31:16];
         end else begin
            pipe_out_data <= head_nxt[15:0];
         end
         if (capture_en && wave_valid && full) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
               drop_count <= drop_count + DROP_CNT_W'(1);
            end
         end
         if (pipe_out_read && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wave_pipe_out.sv
// tb/tb_wave_pipe_out.sv - self-checking bench for wave_pipe_out against a queue model
module tb_wave_pipe_out;

   localparam int DEPTH       = 1024;
   localparam int BLOCK_WORDS = 256;

   logic                      pipe_clk = 1'b0;
   logic                      reset;
   logic                      capture_en;
   logic                      wave_valid;
   logic [31:0]               wave_in;
   logic                      pipe_out_read;
   logic [15:0]               pipe_out_data;
   logic                      pipe_out_ready;
   logic [$clog2(DEPTH)+1:0]  words_avail;
   logic                      full;
   logic                      empty;
   logic                      overflow;
   logic                      underflow;
   logic [15:0]               drop_count;

   wave_pipe_out #(
      .DEPTH       (DEPTH),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) dut (
      .pipe_clk       (pipe_clk),
      .reset          (reset),
      .capture_en     (capture_en),
      .wave_valid     (wave_valid),
      .wave_in        (wave_in),
      .pipe_out_read  (pipe_out_read),
      .pipe_out_data  (pipe_out_data),
      .pipe_out_ready (pipe_out_ready),
      .words_avail    (words_avail),
      .full           (full),
      .empty          (empty),
      .overflow       (overflow),
      .underflow      (underflow),
      .drop_count     (drop_count)
   );

   always #5 pipe_clk = ~pipe_clk;

   // Reference model: buffered samples in order, plus which half is next.
   logic [31:0] q[$];
   bit          m_lo;
   bit          m_of;
   bit          m_uf;
   int          m_drop;

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          chk_en = 1'b0;
   logic [15:0] exp_data;
   logic [31:0] head_s;

   function automatic int m_words();
      return 2 * q.size() - (m_lo ? 1 : 0);
   endfunction

   function automatic logic [31:0] sample(input int k);
      logic [15:0] lo;
      lo = 16'(k);
      return {lo ^ 16'hC3A5, lo};
   endfunction

   function automatic logic [15:0] word_of(input int j);
      logic [31:0] s;
      s = sample(j / 2);
      return (j % 2 == 0) ? s[31:16] : s[15:0];
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic step(input bit cap, input bit v, input logic [31:0] d, input bit rd, input bit rst);
      int w;
      bit f;
      capture_en    = cap;
      wave_valid    = v;
      wave_in       = d;
      pipe_out_read = rd;
      reset         = rst;
      @(posedge pipe_clk);
      if (rst) begin
         q.delete();
         m_lo   = 1'b0;
         m_of   = 1'b0;
         m_uf   = 1'b0;
         m_drop = 0;
      end else begin
         w = m_words();
         f = (q.size() == DEPTH);
         if (rd) begin
            if (w == 0) m_uf = 1'b1;
            else if (!m_lo) m_lo = 1'b1;
            else begin
               m_lo = 1'b0;
               void'(q.pop_front());
            end
         end
         if (cap && v) begin
            if (f) begin
               m_of = 1'b1;
               if (m_drop < 65535) m_drop++;
            end else begin
               q.push_back(d);
            end
         end
      end
      @(negedge pipe_clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [31:0] d);
      step(1'b1, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic rd();
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data"},  32'(pipe_out_data), 32'h0);
      chk({tag, "_words"}, 32'(words_avail), 32'd0);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_full"},  32'(full), 32'd0);
      chk({tag, "_ready"}, 32'(pipe_out_ready), 32'd0);
      chk({tag, "_ovf"},   32'(overflow), 32'd0);
      chk({tag, "_unf"},   32'(underflow), 32'd0);
      chk({tag, "_drops"}, 32'(drop_count), 32'd0);
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge pipe_clk) begin
      if (chk_en) begin
         exp_data = 16'h0000;
         if (m_words() != 0) begin
            head_s   = q[0];
            exp_data = m_lo ? head_s[15:0] : head_s[31:16];
         end
         chk("data",       32'(pipe_out_data), 32'(exp_data));
         chk("words",      32'(words_avail), m_words());
         chk("empty",      32'(empty), 32'(m_words() == 0));
         chk("full",       32'(full), 32'(q.size() == DEPTH));
         chk("ready",      32'(pipe_out_ready), 32'(m_words() >= BLOCK_WORDS));
         chk("overflow",   32'(overflow), 32'(m_of));
         chk("underflow",  32'(underflow), 32'(m_uf));
         chk("drop_count", 32'(drop_count), m_drop);
      end
   end

   initial begin
      int pushed;
      int nread;
      int budget;

      do_reset();
      do_reset();
      chk_en = 1'b1;
      chk_reset_vals("rst");

      // Single sample, high half first.
      push(32'hAAAA5555);
      idle();
      idle();
      chk("t1_hi",     32'(pipe_out_data), 32'h0000AAAA);
      chk("t1_words2", 32'(words_avail), 32'd2);
      rd();
      chk("t1_lo",     32'(pipe_out_data), 32'h00005555);
      chk("t1_words1", 32'(words_avail), 32'd1);
      rd();
      chk("t1_words0", 32'(words_avail), 32'd0);
      chk("t1_empty",  32'(empty), 32'd1);

      // Overfill by three, then drain everything in order.
      do_reset();
      for (int i = 0; i < DEPTH + 3; i++) push(sample(i));
      chk("t2_full",  32'(full), 32'd1);
      chk("t2_ovf",   32'(overflow), 32'd1);
      chk("t2_drops", 32'(drop_count), 32'd3);
      chk("t2_words", 32'(words_avail), 32'(2 * DEPTH));
      for (int j = 0; j < 2 * DEPTH; j++) begin
         chk("t2_word", 32'(pipe_out_data), 32'(word_of(j)));
         rd();
      end
      chk("t2_empty", 32'(empty), 32'd1);

      // Block threshold.
      do_reset();
      for (int i = 0; i < 127; i++) push(sample(i));
      chk("t3_notready", 32'(pipe_out_ready), 32'd0);
      push(sample(127));
      chk("t3_words256", 32'(words_avail), 32'd256);
      chk("t3_ready",    32'(pipe_out_ready), 32'd1);
      rd();
      chk("t3_deassert", 32'(pipe_out_ready), 32'd0);
      for (int j = 0; j < 255; j++) rd();

      // Sparse pushes with back-to-back reads across several pointer wraps.
      do_reset();
      pushed = 0;
      nread  = 0;
      budget = 4 * 3 * DEPTH + 32;
      for (int c = 0; c < budget && (pushed < 3 * DEPTH || m_words() > 0); c++) begin
         if (m_words() > 0) begin
            chk("t4_seq", 32'(pipe_out_data), 32'(word_of(nread)));
            nread++;
         end
         if ((c % 4 == 0) && (pushed < 3 * DEPTH)) begin
            step(1'b1, 1'b1, sample(pushed), m_words() > 0, 1'b0);
            pushed++;
         end else begin
            step(1'b0, 1'b0, 32'h0, m_words() > 0, 1'b0);
         end
      end
      chk("t4_nread", nread, 32'(6 * DEPTH));
      chk("t4_unf",   32'(underflow), 32'd0);
      chk("t4_ovf",   32'(overflow), 32'd0);

      // Read while empty, then recover.
      do_reset();
      rd();
      chk("t5_data",  32'(pipe_out_data), 32'h0);
      chk("t5_unf",   32'(underflow), 32'd1);
      chk("t5_words", 32'(words_avail), 32'd0);
      push(32'h1357_9BDF);
      idle();
      chk("t5_hi", 32'(pipe_out_data), 32'h00001357);
      rd();
      chk("t5_lo", 32'(pipe_out_data), 32'h00009BDF);
      rd();

      // Reset with half_sel=LO discards the partial sample.
      do_reset();
      push(32'hDEAD_BEEF);
      idle();
      rd();
      chk("t6_lo_before", 32'(pipe_out_data), 32'h0000BEEF);
      do_reset();
      chk_reset_vals("t6_rst");
      push(32'hCAFE_F00D);
      idle();
      chk("t6_hi", 32'(pipe_out_data), 32'h0000CAFE);
      rd();
      chk("t6_lo", 32'(pipe_out_data), 32'h0000F00D);
      rd();

      // Randomised traffic with varying fill/drain bias.
      do_reset();
      for (int p = 0; p < 10; p++) begin
         int pv;
         int pr;
         pv = (p % 2 == 0) ? 90 : 30;
         pr = (p % 2 == 0) ? 25 : 85;
         if (p == 7) do_reset();
         for (int c = 0; c < 500; c++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) < pv,
                 $urandom,
                 $urandom_range(0, 99) < pr,
                 1'b0);
         end
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
